// File: rtl/i_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package i_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      RESP
   } state_t;

   localparam logic [31:0] INVALID_ZERO = 32'h0000_0000;
   localparam logic [31:0] INVALID_ONES = 32'hFFFF_FFFF;

   // All-zero and all-ones words are treated as non-instructions.
   function automatic logic word_ok(input logic [31:0] w);
      return (w != INVALID_ZERO) && (w != INVALID_ONES);
   endfunction

endpackage

// File: rtl/i_cache_refill.sv
// Refill sequencer: owns the cache FSM, the beat counter and the memory request port.
module i_cache_refill
   import i_cache_pkg::*;
#(
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned ADDR_W         = 32,
   localparam int unsigned BEAT_W        = $clog2(WORDS_PER_LINE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              abort,
   input  logic              mem_ack,
   output state_t            state,
   output logic [BEAT_W-1:0] beat,
   output logic              fill_we,
   output logic              fill_last,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr
);

   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(WORDS_PER_LINE * 4 - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   state_t            state_nx;
   logic [ADDR_W-1:0] base;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = REFILL;
         REFILL: begin
            if (abort)                               state_nx = IDLE;
            else if (mem_ack && (beat == LAST_BEAT)) state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = (state == REFILL);
      mem_addr  = mem_req ? (base | ADDR_W'({beat, 2'b00})) : '0;
      fill_we   = mem_req && mem_ack && !abort;
      fill_last = fill_we && (beat == LAST_BEAT);
   end

   // Beat count returns to zero whenever the sequencer leaves REFILL.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat <= '0;
         base <= '0;
      end else begin
         if (start && (state == IDLE)) base <= pc_in & ~OFF_MASK;
         if (state != REFILL)          beat <= '0;
         else if (fill_we)             beat <= beat + 1'b1;
      end
   end

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache: tag/data/valid arrays, lookup and response.
// Optional content check of returned lines enabled by I_CACHE_INST_CHECK_EN.
module i_cache_dm
   import i_cache_pkg::*;
#(
   parameter int unsigned NUM_LINES      = 64,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_W-1:0]             pc_in,
   input  logic                          rd_en,
   input  logic                          abort,
   input  logic                          flush,
   output logic                          busy,
   output logic [32*WORDS_PER_LINE-1:0]  Dout,
   output logic                          Dout_valid,
   output logic                          mem_req,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic                          mem_ack,
   input  logic [31:0]                   mem_data
);

   localparam int unsigned LINE_W = 32 * WORDS_PER_LINE;
   localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE * 4);
   localparam int unsigned IDX_W  = $clog2(NUM_LINES);
   localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);

   logic [LINE_W-1:0] data_mem [NUM_LINES];
   logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0] valid;

   state_t            state;
   logic [BEAT_W-1:0] fill_beat;
   logic              fill_we;
   logic              fill_last;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic              flush_seen;
   logic              lookup;
   logic              hit;
   logic              start;
   logic [LINE_W-1:0] rd_line;
   logic              resp_ok;

   i_cache_refill #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .ADDR_W         (ADDR_W)
   ) u_refill (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pc_in     (pc_in),
      .abort     (abort),
      .mem_ack   (mem_ack),
      .state     (state),
      .beat      (fill_beat),
      .fill_we   (fill_we),
      .fill_last (fill_last),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr)
   );

   assign busy = (state != IDLE);

   // A same-cycle flush forces the lookup to miss.
   always_comb begin
      idx     = pc_in[OFF_W +: IDX_W];
      tag     = pc_in[ADDR_W-1 -: TAG_W];
      lookup  = (state == IDLE) && rd_en && !abort;
      hit     = lookup && !flush && valid[idx] && (tag_mem[idx] == tag);
      start   = lookup && !hit;
      rd_line = (state == RESP) ? data_mem[fill_idx] : data_mem[idx];
   end

`ifdef I_CACHE_INST_CHECK_EN
   always_comb begin
      resp_ok = 1'b1;
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
         if (!word_ok(rd_line[32*w +: 32])) resp_ok = 1'b0;
      end
   end
`else
   assign resp_ok = 1'b1;
`endif

   // Arrays and refill target are deliberately left untouched by reset.
   always_ff @(posedge clk) begin
      if (start) begin
         fill_idx <= idx;
         fill_tag <= tag;
      end
      if (fill_we)   data_mem[fill_idx][32*int'(fill_beat) +: 32] <= mem_data;
      if (fill_last) tag_mem[fill_idx] <= fill_tag;
   end

   // A flush seen at any point during a refill keeps that line invalid afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid      <= '0;
         flush_seen <= 1'b0;
      end else begin
         if (start)      flush_seen <= 1'b0;
         else if (flush) flush_seen <= 1'b1;

         if (flush) begin
            valid <= '0;
         end else begin
            if (start)                   valid[idx]      <= 1'b0;
            if (fill_last && !flush_seen) valid[fill_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Dout       <= '0;
         Dout_valid <= 1'b0;
      end else begin
         Dout_valid <= 1'b0;
         if (hit || ((state == RESP) && !abort)) begin
            Dout       <= rd_line;
            Dout_valid <= resp_ok;
         end
      end
   end

endmodule
